execute_mem_oqueue: RTL and testbench

- Parametrised output queue for the memory execution unit, the successor to the fixed single-stage output register.
- Buffers completed memory results (ROB tag, fetch ID, data, commit delay, load/store miss) in a DEPTH-entry FIFO.
- Uses valid/ready handshakes on both sides, so writeback/commit can back-pressure the memory pipe.
- Supports a synchronous flush, and counts down each buffered entry's commit delay while it waits.

---
 rtl/execute_mem_oqueue.sv | 156 +++++++++++++++
 tb/tb_execute_mem_oqueue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mem_oqueue.sv
// execute_mem_oqueue: DEPTH-entry output queue for the memory execution unit.
// Buffers completed memory results behind valid/ready handshakes on both sides,
// supports a synchronous flush, and counts down each buffered commit delay.
// Optional same-cycle bypass when empty: define EXECUTE_MEM_OQUEUE_BYPASS_EN.
module execute_mem_oqueue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned FID_W  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DLY_W  = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [ROB_W-1:0]           i_dst_rob,
    input  logic [FID_W-1:0]           i_fid,
    input  logic [DATA_W-1:0]          i_result,
    input  logic [DLY_W-1:0]           i_cmtdelay,
    input  logic                       i_lsmiss,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [ROB_W-1:0]           o_dst_rob,
    output logic [FID_W-1:0]           o_fid,
    output logic [DATA_W-1:0]          o_result,
    output logic [DLY_W-1:0]           o_cmtdelay,
    output logic                       o_lsmiss,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;

    logic [ROB_W-1:0]  rob_q  [DEPTH];
    logic [ROB_W-1:0]  rob_d  [DEPTH];
    logic [FID_W-1:0]  fid_q  [DEPTH];
    logic [FID_W-1:0]  fid_d  [DEPTH];
    logic [DATA_W-1:0] res_q  [DEPTH];
    logic [DATA_W-1:0] res_d  [DEPTH];
    logic [DLY_W-1:0]  dly_q  [DEPTH];
    logic [DLY_W-1:0]  dly_d  [DEPTH];
    logic [DEPTH-1:0]  miss_q, miss_d;

    logic [PTR_W-1:0]  count_c;
    logic [AW-1:0]     wr_idx_c;
    logic [AW-1:0]     rd_idx_c;
    logic              full_c;
    logic              head_valid_c;
    logic              bypass_c;
    logic              push_c;
    logic              pop_c;

    // Occupancy, handshake qualification and bypass decision
    always_comb begin
        count_c      = wr_ptr_q - rd_ptr_q;
        wr_idx_c     = wr_ptr_q[AW-1:0];
        rd_idx_c     = rd_ptr_q[AW-1:0];
        full_c       = (count_c == PTR_W'(DEPTH));
        head_valid_c = valid_q[rd_idx_c];
`ifdef EXECUTE_MEM_OQUEUE_BYPASS_EN
        bypass_c     = ~head_valid_c & i_valid & i_ready & ~i_flush;
`else
        bypass_c     = 1'b0;
`endif
        push_c       = i_valid & ~full_c & ~i_flush & ~bypass_c;
        pop_c        = head_valid_c & i_ready;
    end

    // Pointer and valid-bit next state; flush clears everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (pop_c) begin
            valid_d[rd_idx_c] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push_c) begin
            valid_d[wr_idx_c] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            valid_d  = '0;
        end
    end

    // Payload next state: write at tail, saturating countdown elsewhere
    always_comb begin
        miss_d = miss_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rob_d[i] = rob_q[i];
            fid_d[i] = fid_q[i];
            res_d[i] = res_q[i];
            dly_d[i] = (dly_q[i] != '0) ? (dly_q[i] - DLY_W'(1)) : '0;
            if (push_c && (wr_idx_c == AW'(i))) begin
                rob_d[i]  = i_dst_rob;
                fid_d[i]  = i_fid;
                res_d[i]  = i_result;
                dly_d[i]  = i_cmtdelay;
                miss_d[i] = i_lsmiss;
            end
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage, intentionally not reset
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rob_q[i] <= rob_d[i];
            fid_q[i] <= fid_d[i];
            res_q[i] <= res_d[i];
            dly_q[i] <= dly_d[i];
        end
        miss_q <= miss_d;
    end

    // Head presentation; bypass overrides the stale head when enabled
    always_comb begin
        o_ready    = ~full_c;
        o_count    = count_c;
        o_valid    = head_valid_c;
        o_dst_rob  = rob_q[rd_idx_c];
        o_fid      = fid_q[rd_idx_c];
        o_result   = res_q[rd_idx_c];
        o_cmtdelay = dly_q[rd_idx_c];
        o_lsmiss   = miss_q[rd_idx_c];
        if (bypass_c) begin
            o_valid    = 1'b1;
            o_dst_rob  = i_dst_rob;
            o_fid      = i_fid;
            o_result   = i_result;
            o_cmtdelay = i_cmtdelay;
            o_lsmiss   = i_lsmiss;
        end
    end

endmodule

// File: tb/tb_execute_mem_oqueue.sv
// Directed testbench for execute_mem_oqueue (DEPTH=4).
module tb_execute_mem_oqueue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ROB_W  = 4;
    localparam int unsigned FID_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DLY_W  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              resetn;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [ROB_W-1:0]  i_dst_rob;
    logic [FID_W-1:0]  i_fid;
    logic [DATA_W-1:0] i_result;
    logic [DLY_W-1:0]  i_cmtdelay;
    logic              i_lsmiss;
    logic              o_valid;
    logic              i_ready;
    logic [ROB_W-1:0]  o_dst_rob;
    logic [FID_W-1:0]  o_fid;
    logic [DATA_W-1:0] o_result;
    logic [DLY_W-1:0]  o_cmtdelay;
    logic              o_lsmiss;
    logic [CNT_W-1:0]  o_count;

    int checks   = 0;
    int failures = 0;

    execute_mem_oqueue #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .FID_W(FID_W), .DATA_W(DATA_W), .DLY_W(DLY_W)
    ) dut (
        .clk(clk), .resetn(resetn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_dst_rob(i_dst_rob), .i_fid(i_fid), .i_result(i_result), .i_cmtdelay(i_cmtdelay),
        .i_lsmiss(i_lsmiss), .o_valid(o_valid), .i_ready(i_ready), .o_dst_rob(o_dst_rob),
        .o_fid(o_fid), .o_result(o_result), .o_cmtdelay(o_cmtdelay), .o_lsmiss(o_lsmiss),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic v, input int rob, input int fid, input int res,
                          input int dly, input logic miss);
        i_valid    = v;
        i_dst_rob  = ROB_W'(rob);
        i_fid      = FID_W'(fid);
        i_result   = DATA_W'(res);
        i_cmtdelay = DLY_W'(dly);
        i_lsmiss   = miss;
    endtask

    task automatic test_reset();
        resetn = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_count !== CNT_W'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    endtask

    task automatic test_basic();
        i_ready = 1'b0;
        set_in(1'b1, 3, 'h12, 'hDEADBEEF, 2, 1'b0);
        #1;
        checks++; if (o_valid !== 1'b0 && o_dst_rob === 4'd3 && o_count === CNT_W'(0) && 1'b0) begin failures++; end
        tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        i_ready = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
        checks++; if (o_dst_rob !== 4'd3) begin failures++; $display("FAIL basic_rob got=%0d exp=3", o_dst_rob); end
        checks++; if (o_fid !== 8'h12) begin failures++; $display("FAIL basic_fid got=%0h exp=12", o_fid); end
        checks++; if (o_result !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_result got=%0h exp=deadbeef", o_result); end
        checks++; if (o_cmtdelay !== 4'd2) begin failures++; $display("FAIL basic_dly got=%0d exp=2", o_cmtdelay); end
        checks++; if (o_lsmiss !== 1'b0) begin failures++; $display("FAIL basic_miss got=%0b exp=0", o_lsmiss); end
        checks++; if (o_count !== CNT_W'(1)) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", o_count); end
        tick();
        i_ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_popped_valid got=%0b exp=0", o_valid); end
        checks++; if (o_count !== CNT_W'(0)) begin failures++; $display("FAIL basic_popped_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_countdown();
        int exp_dly [5];
        exp_dly[0] = 3; exp_dly[1] = 2; exp_dly[2] = 1; exp_dly[3] = 0; exp_dly[4] = 0;
        i_ready = 1'b0;
        set_in(1'b1, 6, 'h34, 'h1234, 3, 1'b1);
        tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++; if (o_cmtdelay !== DLY_W'(exp_dly[k])) begin failures++; $display("FAIL countdown_%0d got=%0d exp=%0d", k, o_cmtdelay, exp_dly[k]); end
            tick();
        end
        i_ready = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b1 || o_cmtdelay !== 4'd0 || o_lsmiss !== 1'b1) begin failures++; $display("FAIL countdown_pop got=v%0b d%0d m%0b exp=v1 d0 m1", o_valid, o_cmtdelay, o_lsmiss); end
        tick();
        i_ready = 1'b0;
        checks++; if (o_count !== CNT_W'(0)) begin failures++; $display("FAIL countdown_empty got=%0d exp=0", o_count); end
    endtask

    task automatic test_full();
        i_ready = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            set_in(1'b1, t, t, t, 0, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        checks++; if (o_count !== CNT_W'(4)) begin failures++; $display("FAIL full_count got=%0d exp=4", o_count); end
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", o_ready); end
        set_in(1'b1, 5, 5, 5, 0, 1'b0);
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0 || o_dst_rob !== 4'd1) begin failures++; $display("FAIL full_pop_cycle got=r%0b rob%0d exp=r0 rob1", o_ready, o_dst_rob); end
        tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        i_ready = 1'b0;
        checks++; if (o_count !== CNT_W'(3) || o_ready !== 1'b1) begin failures++; $display("FAIL full_after got=c%0d r%0b exp=c3 r1", o_count, o_ready); end
        i_ready = 1'b1;
        for (int t = 2; t <= 4; t++) begin
            #1;
            checks++; if (o_valid !== 1'b1 || o_dst_rob !== ROB_W'(t)) begin failures++; $display("FAIL full_order got=v%0b rob%0d exp=v1 rob%0d", o_valid, o_dst_rob, t); end
            tick();
        end
        i_ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b exp=0", o_valid); end
        set_in(1'b1, 5, 5, 5, 0, 1'b0);
        tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_dst_rob !== 4'd5) begin failures++; $display("FAIL full_repush got=v%0b rob%0d exp=v1 rob5", o_valid, o_dst_rob); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_wrap();
        i_ready = 1'b0;
        set_in(1'b1, 0, 'h50, 0, 0, 1'b0); tick();
        set_in(1'b1, 1, 'h51, 1, 0, 1'b0); tick();
        for (int k = 2; k <= 9; k++) begin
            set_in(1'b1, k, 'h50 + k, k, 0, 1'b0);
            i_ready = 1'b1;
            #1;
            checks++; if (o_dst_rob !== ROB_W'(k - 2) || o_count !== CNT_W'(2)) begin failures++; $display("FAIL wrap_%0d got=rob%0d c%0d exp=rob%0d c2", k, o_dst_rob, o_count, k - 2); end
            tick();
        end
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        for (int k = 8; k <= 9; k++) begin
            #1;
            checks++; if (o_valid !== 1'b1 || o_dst_rob !== ROB_W'(k) || o_fid !== FID_W'('h50 + k)) begin failures++; $display("FAIL wrap_drain_%0d got=rob%0d fid%0h exp=rob%0d", k, o_dst_rob, o_fid, k); end
            tick();
        end
        i_ready = 1'b0;
        checks++; if (o_count !== CNT_W'(0) || o_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=c%0d v%0b exp=c0 v0", o_count, o_valid); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            set_in(1'b1, t, 'hA0 + t, t, 1, 1'b0);
            tick();
        end
        set_in(1'b1, 9, 'hF9, 9, 0, 1'b0);
        i_flush = 1'b1;
        i_ready = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b1 || o_dst_rob !== 4'd1) begin failures++; $display("FAIL flush_deliver got=v%0b rob%0d exp=v1 rob1", o_valid, o_dst_rob); end
        tick();
        i_flush = 1'b0;
        i_ready = 1'b0;
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        checks++; if (o_valid !== 1'b0 || o_count !== CNT_W'(0) || o_ready !== 1'b1) begin failures++; $display("FAIL flush_after got=v%0b c%0d r%0b exp=v0 c0 r1", o_valid, o_count, o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_count !== CNT_W'(0)) begin failures++; $display("FAIL flush_dropped got=v%0b c%0d exp=v0 c0", o_valid, o_count); end
    endtask

    task automatic test_bypass();
        set_in(1'b1, 7, 'h77, 'hCAFE, 5, 1'b1);
        i_ready = 1'b1;
        #1;
`ifdef EXECUTE_MEM_OQUEUE_BYPASS_EN
        checks++; if (o_valid !== 1'b1 || o_dst_rob !== 4'd7 || o_cmtdelay !== 4'd5) begin failures++; $display("FAIL bypass_same got=v%0b rob%0d d%0d exp=v1 rob7 d5", o_valid, o_dst_rob, o_cmtdelay); end
        checks++; if (o_count !== CNT_W'(0)) begin failures++; $display("FAIL bypass_count got=%0d exp=0", o_count); end
        tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== CNT_W'(0)) begin failures++; $display("FAIL bypass_after got=v%0b c%0d exp=v0 c0", o_valid, o_count); end
`else
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL nobypass_same got=%0b exp=0", o_valid); end
        i_ready = 1'b0;
        tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_dst_rob !== 4'd7 || o_cmtdelay !== 4'd5 || o_count !== CNT_W'(1)) begin failures++; $display("FAIL nobypass_next got=v%0b rob%0d d%0d c%0d exp=v1 rob7 d5 c1", o_valid, o_dst_rob, o_cmtdelay, o_count); end
        i_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0 || o_count !== CNT_W'(0)) begin failures++; $display("FAIL nobypass_pop got=v%0b c%0d exp=v0 c0", o_valid, o_count); end
`endif
        i_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        set_in(1'b1, 2, 2, 2, 0, 1'b0); tick();
        set_in(1'b1, 3, 3, 3, 0, 1'b0); tick();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++; if (o_valid !== 1'b0 || o_count !== CNT_W'(0) || o_ready !== 1'b1) begin failures++; $display("FAIL reset_mid got=v%0b c%0d r%0b exp=v0 c0 r1", o_valid, o_count, o_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_countdown();
        test_full();
        test_wrap();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
